data_mem_pipelined: RTL and testbench

//  Parametrised single-port data memory for the datapath: next generation of the flat data RAM.

---
 rtl/data_mem_pipelined.sv | 153 +++++++++++++++
 tb/tb_data_mem_pipelined.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipelined.sv
// Single-port data memory with a valid/ready request port, byte-enable writes,
// range checking, 1- or 2-cycle registered read responses and an optional post-reset clear sweep.
module data_mem_pipelined #(
    parameter int    DATA_W         = 16,
    parameter int    ADDR_W         = 16,
    parameter int    DEPTH          = 256,
    parameter int    RD_LAT         = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "Data.mem"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    clr_cnt_r;
    logic                ready_r;
    logic                busy_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                s1_valid_r;
    logic                s1_err_r;
    logic [DATA_W-1:0]   s1_rdata_r;

    logic                accept_s;
    logic                in_range_s;
    logic                clr_we_s;
    logic [IDX_W-1:0]    req_idx_s;

    // Request qualification; the address is compared at full width so nothing wraps.
    always_comb begin
        accept_s   = req_valid & ready_r & ~rst;
        in_range_s = ({1'b0, req_addr} < DEPTH_A);
        req_idx_s  = req_addr[IDX_W-1:0];
        clr_we_s   = (state_r == ST_CLEAR) & ~rst;
    end

    // Sweep/run control with registered ready and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + IDX_W'(1);
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_RUN;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: sweep zeroing or byte-enabled in-range writes. Contents survive reset.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (accept_s & req_we & in_range_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem_r[req_idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // First response stage: read data registered at the accept edge, zero for writes and errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
            s1_rdata_r <= '0;
        end else begin
            s1_valid_r <= accept_s;
            s1_err_r   <= accept_s & ~in_range_s;
            if (accept_s & ~req_we & in_range_s) begin
                s1_rdata_r <= mem_r[req_idx_s];
            end else begin
                s1_rdata_r <= '0;
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic                s2_valid_r;
            logic                s2_err_r;
            logic [DATA_W-1:0]   s2_rdata_r;

            // Extra output stage; a reset drops whatever is still in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_r <= 1'b0;
                    s2_err_r   <= 1'b0;
                    s2_rdata_r <= '0;
                end else begin
                    s2_valid_r <= s1_valid_r;
                    s2_err_r   <= s1_err_r;
                    s2_rdata_r <= s1_rdata_r;
                end
            end

            assign rsp_valid = s2_valid_r;
            assign rsp_err   = s2_err_r;
            assign rsp_rdata = s2_rdata_r;
        end else begin : g_lat1
            assign rsp_valid = s1_valid_r;
            assign rsp_err   = s1_err_r;
            assign rsp_rdata = s1_rdata_r;
        end
    endgenerate

    assign req_ready = ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_pipelined.sv
// Two DUT configurations driven by a shared request stream (256 words/latency 1/clear,
// 200 words/latency 2/no clear) checked against a transaction-level memory model every cycle.
module tb_data_mem_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [15:0] req_addr  = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic [1:0]  req_be    = 2'b00;

    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic        bsy [2];
    logic [15:0] dat [2];

    data_mem_pipelined #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1),
                         .CLEAR_ON_RESET(1), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[0]), .rsp_rdata(dat[0]), .rsp_err(err[0]), .busy(bsy[0]));

    data_mem_pipelined #(.DATA_W(16), .ADDR_W(16), .DEPTH(200), .RD_LAT(2),
                         .CLEAR_ON_RESET(0), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[1]), .rsp_rdata(dat[1]), .rsp_err(err[1]), .busy(bsy[1]));

    typedef struct {
        int          due;
        bit          v;
        logic [15:0] data;
        bit          err;
        bit          dc;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] x0;
        bit          e0;
        logic [15:0] x1;
        bit          e1;
        bit          c1;
    } vec_t;

    rsp_t        rq0[$];
    rsp_t        rq1[$];
    int          dep [2] = '{256, 200};
    int          lat [2] = '{1, 2};
    int          clr [2] = '{1, 0};
    logic [15:0] mm  [2][256];
    bit          kn  [2][256];
    bit          exp_rdy [2];
    bit          exp_bsy [2];
    int          nrun = 0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Transaction-level effect of an accepted request on one DUT's memory image.
    task automatic model_accept(input int d);
        rsp_t r;
        int   a;
        a      = int'(req_addr);
        r.due  = cyc + lat[d];
        r.v    = 1'b1;
        r.err  = (a >= dep[d]);
        r.data = 16'h0;
        r.dc   = 1'b0;
        if (!r.err && req_we) begin
            if (req_be[0]) mm[d][a][7:0]  = req_wdata[7:0];
            if (req_be[1]) mm[d][a][15:8] = req_wdata[15:8];
            if (req_be == 2'b11) kn[d][a] = 1'b1;
        end else if (!r.err) begin
            r.data = mm[d][a];
            r.dc   = !kn[d][a];
        end
        if (d == 0) rq0.push_back(r);
        else        rq1.push_back(r);
    endtask

    // One clock: update the model, advance, and compare every output of both DUTs.
    task automatic step();
        rsp_t        r;
        logic [31:0] got;
        logic [31:0] exp;
        for (int d = 0; d < 2; d++)
            if (!rst && req_valid && exp_rdy[d]) model_accept(d);
        if (rst) begin
            rq0.delete();
            rq1.delete();
            nrun = 0;
            for (int d = 0; d < 2; d++)
                if (clr[d] != 0)
                    for (int a = 0; a < 256; a++) begin
                        mm[d][a] = 16'h0;
                        kn[d][a] = 1'b1;
                    end
        end else begin
            nrun++;
        end
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = !rst && ((clr[d] != 0) ? (nrun >= dep[d]) : (nrun >= 1));
            exp_bsy[d] = !rst && (clr[d] != 0) && (nrun < dep[d]);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            r = '{0, 1'b0, 16'h0, 1'b0, 1'b0};
            if (d == 0 && rq0.size() > 0 && rq0[0].due == cyc) r = rq0.pop_front();
            if (d == 1 && rq1.size() > 0 && rq1[0].due == cyc) r = rq1.pop_front();
            got = {12'h0, rdy[d], bsy[d], vld[d], err[d], r.dc ? 16'h0 : dat[d]};
            exp = {12'h0, exp_rdy[d], exp_bsy[d], r.v, r.err, r.dc ? 16'h0 : r.data};
            check($sformatf("dut%0d cyc%0d rdy/busy/vld/err/data", d, cyc), got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy[0] !== 1'b1 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [15];
        int          n;
        logic [16:0] obs0 [12];
        logic [16:0] obs1 [12];
        logic [15:0] rdv  [5];

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) begin
                mm[d][a] = 16'h0;
                kn[d][a] = 1'b0;
            end

        //        we    addr      wdata     be     x0        e0    x1        e1    c1
        vt[0]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 16'h0005, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 16'h0005, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 16'h0005, 16'h1234, 2'b01, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 16'h0005, 16'h0000, 2'b00, 16'hBE34, 1'b0, 16'hBE34, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 16'h0005, 16'h9999, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 16'h0005, 16'h0000, 2'b00, 16'hBE34, 1'b0, 16'hBE34, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 16'd210,  16'hFFFF, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 16'd210,  16'h0000, 2'b00, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 16'd199,  16'hAAAA, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vt[10] = '{1'b0, 16'd199,  16'h0000, 2'b00, 16'hAAAA, 1'b0, 16'hAAAA, 1'b0, 1'b1};
        vt[11] = '{1'b0, 16'h00FF, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[12] = '{1'b1, 16'h0100, 16'h5555, 2'b11, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vt[13] = '{1'b0, 16'h0100, 16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vt[14] = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};

        // Reset for two cycles, then the clear sweep.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_ready(n);
        check("sweep length after reset", 32'(n), 32'd256);

        // Directed table: one request, then observe each DUT's response at its latency.
        for (int i = 0; i < 15; i++) begin
            issue(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be);
            step();
            req_valid = 1'b0;
            check($sformatf("vec%0d dut0 rsp", i), {15'h0, vld[0], err[0], dat[0]},
                  {15'h0, 1'b1, vt[i].e0, vt[i].x0});
            step();
            if (vt[i].c1)
                check($sformatf("vec%0d dut1 rsp", i), {15'h0, vld[1], err[1], dat[1]},
                      {15'h0, 1'b1, vt[i].e1, vt[i].x1});
        end

        // Back-to-back writes then back-to-back reads, first read right after the last write.
        rdv = '{16'h0044, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
        for (int k = 0; k < 12; k++) begin
            if (k < 4)       issue(1'b1, 16'(k), 16'(8'h11 * (k + 1)), 2'b11);
            else if (k == 4) issue(1'b0, 16'h0003, 16'h0, 2'b00);
            else if (k < 9)  issue(1'b0, 16'(k - 5), 16'h0, 2'b00);
            else             req_valid = 1'b0;
            step();
            obs0[k] = {vld[0], dat[0]};
            obs1[k] = {vld[1], dat[1]};
        end
        for (int j = 0; j < 5; j++) begin
            check($sformatf("burst dut0 rsp%0d", j), 32'(obs0[4 + j]), 32'({1'b1, rdv[j]}));
            check($sformatf("burst dut1 rsp%0d", j), 32'(obs1[5 + j]), 32'({1'b1, rdv[j]}));
        end
        check("burst dut1 tail idle", 32'(obs1[10][16]), 32'd0);

        // Reset with reads in flight: nothing stale may appear, sweep restarts.
        issue(1'b0, 16'h0005, 16'h0, 2'b00);
        step();
        issue(1'b0, 16'h0006, 16'h0, 2'b00);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        check("reset drops dut0 rsp", 32'(vld[0]), 32'd0);
        check("reset drops dut1 rsp", 32'(vld[1]), 32'd0);
        rst = 1'b0;
        wait_ready(n);
        check("sweep length after mid-run reset", 32'(n), 32'd256);
        issue(1'b0, 16'h0005, 16'h0, 2'b00);
        step();
        req_valid = 1'b0;
        check("post-clear dut0 read 5", {15'h0, vld[0], err[0], dat[0]}, {15'h0, 1'b1, 1'b0, 16'h0000});
        step();
        check("kept dut1 read 5", {15'h0, vld[1], err[1], dat[1]}, {15'h0, 1'b1, 1'b0, 16'hBE34});

        // Random traffic against the model, addresses straddling both depths.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 259));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
            step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("all responses delivered", 32'(rq0.size() + rq1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
